// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential matrix multiply-accumulate engine.
// Covers FSM state encoding, accumulator/index width derivation and the saturation range test.
package matmul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mm_state_t;

  // Widest intermediate value the saturation helper can inspect.
  localparam int unsigned SAT_MAX_W = 256;

  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned k);
    return 2 * data_w + $clog2(k) + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returns 1 when v falls outside the signed range of a w-bit word and must be clipped.
  function automatic logic sat_to_width(input logic signed [SAT_MAX_W-1:0] v,
                                        input int unsigned w);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (SAT_MAX_W'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate register: acc += a*b when en, zeroed by clear.
// sum exposes the value the accumulator would take this cycle (acc + a*b).
module mac_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 66
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;

  always_comb begin
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    sum  = acc_q + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// Sequential signed fixed-point matrix multiply C = A*B or C += A*B using one shared MAC.
// Elements are produced row-major; each takes K enabled cycles, then shift/add/saturate writeback.
module matrix_mac_engine
  import matmul_pkg::*;
#(
  parameter int unsigned M      = 2,
  parameter int unsigned K      = 2,
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         start,
  input  logic                         accumulate,
  input  logic [M*K-1:0][DATA_W-1:0]   matrix_a,
  input  logic [K*N-1:0][DATA_W-1:0]   matrix_b,
  output logic [M*N-1:0][DATA_W-1:0]   result_matrix,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int unsigned ACC_W = acc_width(DATA_W, K);
  localparam int unsigned IW    = idx_width(M);
  localparam int unsigned JW    = idx_width(N);
  localparam int unsigned KW    = idx_width(K);
  localparam int unsigned AW    = idx_width(M * K);
  localparam int unsigned BW    = idx_width(K * N);
  localparam int unsigned CW    = idx_width(M * N);

  mm_state_t                  state_q;
  logic [IW-1:0]              i_q;
  logic [JW-1:0]              j_q;
  logic [KW-1:0]              k_q;
  logic [M*K-1:0][DATA_W-1:0] a_q;
  logic [K*N-1:0][DATA_W-1:0] b_q;
  logic                       accumulate_q;

  logic [AW-1:0] a_idx;
  logic [BW-1:0] b_idx;
  logic [CW-1:0] c_idx;
  logic          i_last, j_last, k_last;

  logic                     mac_clear, mac_en;
  logic signed [ACC_W-1:0]  mac_sum, acc_shift, c_old, wb_sum;
  logic [DATA_W-1:0]        c_cur, wb_value;
  logic                     wb_clip;

  always_comb begin
    a_idx  = AW'(32'(i_q) * K + 32'(k_q));
    b_idx  = BW'(32'(k_q) * N + 32'(j_q));
    c_idx  = CW'(32'(i_q) * N + 32'(j_q));
    i_last = (32'(i_q) == M - 1);
    j_last = (32'(j_q) == N - 1);
    k_last = (32'(k_q) == K - 1);
  end

  // The accumulator restarts both on an accepted start and after each finished element.
  assign mac_clear = enable && (((state_q == IDLE) && start) || ((state_q == RUN) && k_last));
  assign mac_en    = enable && (state_q == RUN);

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (a_q[a_idx]),
    .b     (b_q[b_idx]),
    .sum   (mac_sum)
  );

  // Floor-rounded rescale, optional add of the previous C element, then clip to DATA_W.
  always_comb begin
    c_cur     = result_matrix[c_idx];
    acc_shift = mac_sum >>> FRAC_W;
    c_old     = $signed({{(ACC_W-DATA_W){c_cur[DATA_W-1]}}, c_cur});
    wb_sum    = accumulate_q ? (acc_shift + c_old) : acc_shift;
    wb_clip   = sat_to_width(SAT_MAX_W'(wb_sum), DATA_W);
    if (!wb_clip) begin
      wb_value = wb_sum[DATA_W-1:0];
    end else if (wb_sum[ACC_W-1]) begin
      wb_value = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      wb_value = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      accumulate_q  <= 1'b0;
      result_matrix <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q          <= matrix_a;
            b_q          <= matrix_b;
            accumulate_q <= accumulate;
            overflow     <= 1'b0;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            busy         <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (k_last) begin
            k_q                  <= '0;
            result_matrix[c_idx] <= wb_value;
            if (wb_clip) overflow <= 1'b1;
            if (j_last) begin
              j_q <= '0;
              if (i_last) begin
                i_q     <= '0;
                busy    <= 1'b0;
                state_q <= DONE;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine across four shape/width configurations.
// Expected matrices, latencies and flags are hand-computed constants.
module tb_matrix_mac_engine;

  logic clk = 1'b0;
  logic reset, enable, accumulate;
  logic start1, start2, start3, start4;

  logic [3:0][31:0] a1, b1, c1;
  logic [5:0][31:0] a2;
  logic [2:0][31:0] b2;
  logic [1:0][31:0] c2;
  logic [0:0][15:0] a3, b3, c3;
  logic [1:0][7:0]  a4, b4;
  logic [0:0][7:0]  c4;
  logic busy1, done1, ovf1, busy2, done2, ovf2, busy3, done3, ovf3, busy4, done4, ovf4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  matrix_mac_engine u_d1 (
    .clk(clk), .reset(reset), .enable(enable), .start(start1), .accumulate(accumulate),
    .matrix_a(a1), .matrix_b(b1), .result_matrix(c1), .busy(busy1), .done(done1),
    .overflow(ovf1)
  );

  matrix_mac_engine #(.M(2), .K(3), .N(1)) u_d2 (
    .clk(clk), .reset(reset), .enable(enable), .start(start2), .accumulate(accumulate),
    .matrix_a(a2), .matrix_b(b2), .result_matrix(c2), .busy(busy2), .done(done2),
    .overflow(ovf2)
  );

  matrix_mac_engine #(.M(1), .K(1), .N(1), .DATA_W(16), .FRAC_W(8)) u_d3 (
    .clk(clk), .reset(reset), .enable(enable), .start(start3), .accumulate(accumulate),
    .matrix_a(a3), .matrix_b(b3), .result_matrix(c3), .busy(busy3), .done(done3),
    .overflow(ovf3)
  );

  matrix_mac_engine #(.M(1), .K(2), .N(1), .DATA_W(8)) u_d4 (
    .clk(clk), .reset(reset), .enable(enable), .start(start4), .accumulate(accumulate),
    .matrix_a(a4), .matrix_b(b4), .result_matrix(c4), .busy(busy4), .done(done4),
    .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the selected unit's done is seen, bounded at 100.
  task automatic wait_done(input int unit, output int n);
    logic d;
    n = 0;
    do begin
      tick();
      n++;
      case (unit)
        1:       d = done1;
        2:       d = done2;
        3:       d = done3;
        default: d = done4;
      endcase
    end while (!d && n < 100);
  endtask

  task automatic load_t1();
    a1 = {32'd1, 32'd1, 32'd2, 32'd1};  // A = [1,2;1,1]
    b1 = {32'd1, 32'd1, 32'd1, 32'd1};
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b1; enable = 1'b1; accumulate = 1'b0;
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0; start4 = 1'b0;
    load_t1();
    a2 = '0; b2 = '0; a3 = '0; b3 = '0; a4 = '0; b4 = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset c", 64'(c1), 64'd0);
    check("reset busy", 64'(busy1), 64'd0);
    check("reset done", 64'(done1), 64'd0);
    check("reset ovf", 64'(ovf1), 64'd0);

    // Test 1: plain multiply; operands scrambled after the start edge.
    start1 = 1'b1; tick(); start1 = 1'b0;
    a1 = '1; b1 = '1;
    check("t1 busy", 64'(busy1), 64'd1);
    wait_done(1, n);
    check("t1 latency", 64'(n), 64'd9);
    check("t1 c00", 64'(c1[0]), 64'd3);
    check("t1 c01", 64'(c1[1]), 64'd3);
    check("t1 c10", 64'(c1[2]), 64'd2);
    check("t1 c11", 64'(c1[3]), 64'd2);
    check("t1 ovf", 64'(ovf1), 64'd0);
    check("t1 busy end", 64'(busy1), 64'd0);
    tick();
    check("t1 done pulse", 64'(done1), 64'd0);

    // Test 5: accumulate onto previous result.
    load_t1();
    accumulate = 1'b1; start1 = 1'b1; tick(); start1 = 1'b0; accumulate = 1'b0;
    wait_done(1, n);
    check("t5 latency", 64'(n), 64'd9);
    check("t5 c", 64'(c1), {32'd4, 32'd4, 32'd6, 32'd6});

    // Test 6a: 3-cycle stall plus an ignored start during RUN.
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    start1 = 1'b1; tick(); start1 = 1'b0;
    enable = 1'b0; tick(); tick(); tick();
    check("t6 stall busy", 64'(busy1), 64'd1);
    enable = 1'b1;
    wait_done(1, n);
    check("t6 stall latency", 64'(n + 5), 64'd12);
    check("t6 stall c", 64'(c1), {32'd2, 32'd2, 32'd3, 32'd3});
    tick();
    check("t6 no requeue", 64'(busy1), 64'd0);

    // Test 6b: reset on the fourth RUN edge aborts.
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6 abort c", 64'(c1), 64'd0);
    check("t6 abort busy", 64'(busy1), 64'd0);
    seen = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (done1) seen++;
    end
    check("t6 abort no done", 64'(seen), 64'd0);

    // Test 2: 2x3 * 3x1.
    a2 = {32'd6, -32'sd5, 32'd4, 32'd3, 32'd2, -32'sd1};
    b2 = {32'd9, -32'sd8, 32'd7};
    start2 = 1'b1; tick(); start2 = 1'b0;
    wait_done(2, n);
    check("t2 latency", 64'(n), 64'd7);
    check("t2 c0", 64'(c2[0]), 64'd4);
    check("t2 c1", 64'(c2[1]), 64'd122);

    // Test 3: Q8.8 1.5 * -2.25.
    a3 = 16'h0180; b3 = 16'hFDC0;
    start3 = 1'b1; tick(); start3 = 1'b0;
    wait_done(3, n);
    check("t3 latency", 64'(n), 64'd2);
    check("t3 c", 64'(c3), 64'hFCA0);
    check("t3 ovf", 64'(ovf3), 64'd0);

    // Test 4: 8-bit positive saturation, clear on next start, negative saturation.
    a4 = {8'd100, 8'd100}; b4 = {8'd100, 8'd100};
    start4 = 1'b1; tick(); start4 = 1'b0;
    wait_done(4, n);
    check("t4 latency", 64'(n), 64'd3);
    check("t4 c sat+", 64'(c4), 64'h7F);
    check("t4 ovf", 64'(ovf4), 64'd1);
    a4 = {8'd1, 8'd1}; b4 = {8'd1, 8'd1};
    start4 = 1'b1; tick(); start4 = 1'b0;
    check("t4 ovf cleared", 64'(ovf4), 64'd0);
    wait_done(4, n);
    check("t4 c small", 64'(c4), 64'd2);
    check("t4 ovf small", 64'(ovf4), 64'd0);
    a4 = {8'd100, 8'h9C}; b4 = {8'd100, 8'd100};  // -100*100 + 100*100 = 0
    start4 = 1'b1; tick(); start4 = 1'b0;
    wait_done(4, n);
    check("t4 c zero", 64'(c4), 64'd0);
    a4 = {8'h9C, 8'h9C};                          // -20000 clips low
    start4 = 1'b1; tick(); start4 = 1'b0;
    wait_done(4, n);
    check("t4 c sat-", 64'(c4), 64'h80);
    check("t4 ovf neg", 64'(ovf4), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
